// File: rtl/uart_tx_fifo.sv
// Transmit buffer ahead of the UART: a register-array FIFO plus a launch FSM.
// The FSM hands one byte at a time to the UART over the din/din_vld/rfd handshake.
module uart_tx_fifo #(
  parameter int DI_WIDTH = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DI_WIDTH-1:0] wr_data,
  input  logic                wr_en,
  output logic                full,
  output logic                empty,
  output logic [AW:0]         level,
  output logic                overflow,
  input  logic                ovf_clr,
  output logic [DI_WIDTH-1:0] uart_din,
  output logic                uart_din_vld,
  input  logic                uart_rfd,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t              state_q;
  logic [DI_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         level_q, level_d;
  logic                full_q, empty_q, ovf_q;
  logic [DI_WIDTH-1:0] din_q;
  logic                vld_q;
  logic                push, pop;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign push = wr_en && !full_q;
  assign pop  = (state_q == IDLE) && !empty_q && uart_rfd;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      empty_q <= (level_d == '0);
      if (wr_en && full_q) ovf_q <= 1'b1;
      else if (ovf_clr)    ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rptr_q  <= '0;
      din_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vld_q <= 1'b0;
          if (pop) begin
            din_q   <= mem_q[rptr_q];
            rptr_q  <= rptr_q + PTR_ONE;
            vld_q   <= 1'b1;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          vld_q <= 1'b0;
          if (!uart_rfd) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          vld_q <= 1'b0;
          if (uart_rfd) state_q <= IDLE;
        end
        default: begin
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign uart_din     = din_q;
  assign uart_din_vld = vld_q;
  assign busy         = !empty_q || (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed steps then random traffic, checked each cycle
// against a queue-based model of the buffer and the UART handshake.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          full, empty, overflow, uart_din_vld, busy;
  logic [AW:0]   level;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] uart_din;
  logic          uart_rfd = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_fifo #(.DI_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr), .uart_din(uart_din), .uart_din_vld(uart_din_vld),
    .uart_rfd(uart_rfd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: contents as a queue; a byte "in flight" is done once rfd
  // has been seen low and then high again after its launch.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_fly, m_low, m_vld;
  logic [DW-1:0] m_din;

  // UART model: rfd stays high k_pre cycles after a strobe, then low k_low cycles.
  int u_pre = 0, u_low = 0, k_pre = 1, k_low = 20;
  bit rnd_uart = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_fly = 0; m_low = 0; m_vld = 0; m_din = '0;
    u_pre = 0; u_low = 0;
  endtask

  task automatic model_step(bit wr, logic [DW-1:0] d, bit clr, bit rfd);
    bit was_full = (mq.size() == DEPTH);
    bit launch   = !m_fly && (mq.size() != 0) && rfd;
    m_vld = launch;
    if (launch) begin
      m_din = mq.pop_front();
      m_fly = 1; m_low = 0;
    end else if (m_fly) begin
      if (!m_low) begin
        if (!rfd) m_low = 1;
      end else if (rfd) m_fly = 0;
    end
    if (wr && !was_full) mq.push_back(d);
    if (wr && was_full) m_ovf = 1;
    else if (clr)       m_ovf = 0;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("level",    32'(level),        32'(mq.size()));
    chk("empty",    32'(empty),        32'(mq.size() == 0));
    chk("full",     32'(full),         32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow),     32'(m_ovf));
    chk("din_vld",  32'(uart_din_vld), 32'(m_vld));
    chk("din",      32'(uart_din),     32'(m_din));
    chk("busy",     32'(busy),         32'((mq.size() != 0) || m_fly));
  endtask

  task automatic cycle(bit wr, logic [DW-1:0] d, bit clr, bit rfd);
    wr_en = wr; wr_data = d; ovf_clr = clr; uart_rfd = rfd;
    model_step(wr, d, clr, rfd);
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (m_vld) begin
      if (rnd_uart) begin
        k_pre = $urandom_range(0, 2);
        k_low = $urandom_range(1, 6);
      end
      u_pre = k_pre; u_low = k_low;
    end
  endtask

  task automatic uart_cycle(bit wr, logic [DW-1:0] d, bit clr);
    bit r;
    if (u_pre > 0)      begin r = 1; u_pre--; end
    else if (u_low > 0) begin r = 0; u_low--; end
    else                r = 1;
    cycle(wr, d, clr, r);
  endtask

  task automatic drain();
    int n = 0;
    while (((mq.size() != 0) || m_fly) && n < 4000) begin
      uart_cycle(0, '0, 0);
      n++;
    end
    chk("drain_timeout", 32'(n >= 4000), 32'd0);
  endtask

  initial begin
    model_reset();
    // Reset and idle
    #1 rst = 1'b1;
    repeat (3) begin @(negedge clk); check_all(); end
    rst = 1'b0;
    repeat (5) cycle(0, '0, 0, 1);

    // Single byte: strobe two edges after the write, rfd low for 100 cycles
    k_pre = 1; k_low = 100;
    uart_cycle(1, 8'hA5, 0);
    uart_cycle(0, '0, 0);
    chk("a5_vld", 32'(uart_din_vld), 32'd1);
    chk("a5_din", 32'(uart_din), 32'hA5);
    drain();

    // Burst of five with a slow UART
    k_pre = 1; k_low = 20;
    for (int i = 1; i <= 5; i++) uart_cycle(1, 8'(i), 0);
    drain();

    // Fill past full with rfd low, then clear and re-trigger overflow
    for (int i = 0; i < 17; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    chk("full16",  32'(full), 32'd1);
    chk("lvl16",   32'(level), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    cycle(0, '0, 1, 0);
    chk("ovf_clr", 32'(overflow), 32'd0);
    cycle(1, 8'hEE, 1, 0);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cycle(0, '0, 1, 0);
    k_pre = 0; k_low = 3;
    uart_cycle(0, '0, 0);
    chk("first_out", 32'(uart_din), 32'h40);
    drain();

    // Simultaneous push and pop at level 3
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h60 + i), 0, 0);
    cycle(1, 8'h63, 0, 1);
    chk("lvl3_hold", 32'(level), 32'd3);
    drain();

    // Reset while six bytes queued and the FSM awaits the ack
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'h70 + i), 0, 0);
    cycle(0, '0, 0, 1);
    chk("pre_rst_lvl", 32'(level), 32'd6);
    rst = 1'b1;
    #1;
    chk("rst_vld",   32'(uart_din_vld), 32'd0);
    chk("rst_lvl",   32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    cycle(1, 8'h3C, 0, 1);
    cycle(0, '0, 0, 1);
    chk("post_rst_din", 32'(uart_din), 32'h3C);
    chk("post_rst_vld", 32'(uart_din_vld), 32'd1);
    drain();

    // Random traffic with a randomly paced UART
    rnd_uart = 1'b1;
    for (int blk = 0; blk < 15; blk++) begin
      int p = $urandom_range(0, 4);
      for (int c = 0; c < 200; c++)
        uart_cycle($urandom_range(0, 3) < p, 8'($urandom), $urandom_range(0, 15) == 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
